seq_pattern_gen: RTL and testbench

Programmable, parametrised sequence generator: the successor to the fixed six-state "001011" generator. It replays a stored pattern of up to MAX_LEN symbols, each DATA_W bits wide, over a valid/ready stream. It runs in repeat or one-shot mode, with start/stop control and a configuration port. It powers up holding the legacy pattern 0,0,1,0,1,1 (length 6), so existing users get the old waveform after start with no configuration.

---
 rtl/seq_gen_pkg.sv | 15 +
 rtl/seq_pattern_gen_if.sv | 24 ++
 rtl/seq_pattern_regfile.sv | 38 +++
 rtl/seq_pattern_gen.sv | 124 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types and power-up constants for seq_pattern_gen
// Purpose: FSM state type plus the legacy "001011" pattern loaded at reset.
// Ports: none (package).
package seq_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Entry 0 is the LSB: entries 0..5 read 0,0,1,0,1,1.
  localparam logic [5:0] DEFAULT_PATTERN = 6'b110100;
  localparam int         DEFAULT_LEN     = 6;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - valid/ready symbol stream between generator and sink
// Purpose: bundles the output stream of seq_pattern_gen.
// Ports: out_valid/out_data driven by master, out_ready driven by slave.
interface seq_pattern_gen_if #(
  parameter int DATA_W = 1
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/seq_pattern_regfile.sv
// rtl/seq_pattern_regfile.sv - pattern storage with legacy power-up contents
// Purpose: MAX_LEN x DATA_W flop array, async reset to the legacy pattern.
// Ports: clk, rst_n; we/waddr/wdata synchronous write; raddr/rdata combinational read.
module seq_pattern_regfile
  import seq_gen_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Legacy pattern widened to the full depth so every entry has a reset bit.
  localparam logic [MAX_LEN-1:0] RESET_BITS = MAX_LEN'(DEFAULT_PATTERN);

  logic [DATA_W-1:0] mem [MAX_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem[i] <= DATA_W'(RESET_BITS[i]);
      end
    end else if (we && (int'(waddr) < MAX_LEN)) begin
      // Addresses past the depth only exist for non-power-of-2 MAX_LEN.
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - programmable repeat/one-shot pattern replay over a stream
// Purpose: replays pat[0..len-1] on out_if; start/stop control, IDLE-only config.
// Ports: clk, rst_n; cfg_we/cfg_addr/cfg_wdata pattern write; cfg_len_we/cfg_len
//        length write; mode/start/stop control; out_if stream (master);
//        busy, done (one-shot finished), wrap (repeat returned to entry 0).
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = $clog2(MAX_LEN),
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_wdata,
  input  logic                 cfg_len_we,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 stop,
  seq_pattern_gen_if.master    out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [LEN_W-1:0]  len, len_n;
  logic              run_mode, run_mode_n;
  logic              done_n, wrap_n;
  logic              beat, last;
  logic              idle;
  logic [DATA_W-1:0] rd_data;

  assign idle = (state == IDLE);
  assign beat = (state == RUN) && out_if.out_ready;
  assign last = (LEN_W'(idx) == (len - LEN_W'(1)));

  seq_pattern_regfile #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && idle),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= LEN_W'(DEFAULT_LEN);
      run_mode <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      run_mode <= run_mode_n;
      done     <= done_n;
      wrap     <= wrap_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    len_n      = len;
    run_mode_n = run_mode;
    done_n     = 1'b0;
    wrap_n     = 1'b0;

    // Zero and over-depth lengths would leave idx with no reachable last entry.
    if (idle && cfg_len_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN))) begin
      len_n = cfg_len;
    end

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n    = RUN;
          idx_n      = '0;
          run_mode_n = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (beat) begin
          if (!last) begin
            idx_n = idx + ADDR_W'(1);
          end else if (run_mode) begin
            state_n = IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n  = '0;
            wrap_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign busy             = (state == RUN);
  assign out_if.out_valid = (state == RUN);
  assign out_if.out_data  = (state == RUN) ? rd_data : '0;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

  localparam int DATA_W  = 2;
  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = $clog2(MAX_LEN);
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_len_we;
  logic [LEN_W-1:0]  cfg_len;
  logic              mode;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic              wrap;

  seq_pattern_gen_if #(.DATA_W(DATA_W)) out_if ();

  seq_pattern_gen #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_len_we (cfg_len_we),
    .cfg_len    (cfg_len),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int legacy [6] = '{0, 0, 1, 0, 1, 1};
  int custom [3] = '{3, 1, 2};

  task automatic chk(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            eidx;
    int            ewrap;
    logic [15:0]   rdy_pat;

    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    cfg_len_we = 1'b0;
    cfg_len    = '0;
    mode       = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    out_if.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_if.out_valid), 0);
    chk("rst_data",  int'(out_if.out_data), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_wrap",  int'(wrap), 0);
    rst_n = 1'b1;
    tick();

    // Legacy repeat playback, no configuration.
    mode = 1'b0; start = 1'b1; out_if.out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("legacy_data%0d", k), int'(out_if.out_data), legacy[k % 6]);
      chk($sformatf("legacy_valid%0d", k), int'(out_if.out_valid), 1);
      chk($sformatf("legacy_wrap%0d", k), int'(wrap), (k != 0 && k % 6 == 0) ? 1 : 0);
      tick();
    end
    tick();
    tick();
    // idx is now 3; stop together with a beat.
    chk("pre_stop_data", int'(out_if.out_data), legacy[3]);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", int'(out_if.out_valid), 0);
    chk("stop_busy",  int'(busy), 0);
    chk("stop_done",  int'(done), 0);
    chk("stop_wrap",  int'(wrap), 0);
    chk("stop_data",  int'(out_if.out_data), 0);

    // Illegal lengths in IDLE.
    cfg_len_we = 1'b1; cfg_len = LEN_W'(0);
    tick();
    cfg_len = LEN_W'(MAX_LEN + 1);
    tick();
    cfg_len_we = 1'b0;

    // Restart stalled, then attempt writes while busy.
    mode = 1'b0; start = 1'b1; out_if.out_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_valid", int'(out_if.out_valid), 1);
    chk("restart_data",  int'(out_if.out_data), legacy[0]);
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = 2'd3;
    cfg_len_we = 1'b1; cfg_len = LEN_W'(2);
    tick();
    cfg_we = 1'b0; cfg_len_we = 1'b0;

    // Backpressure run: stalls hold data, len must still be 6.
    eidx = 0; ewrap = 0;
    rdy_pat = 16'b1011_0111_0011_1101;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("bp_data%0d", k), int'(out_if.out_data), legacy[eidx]);
      chk($sformatf("bp_valid%0d", k), int'(out_if.out_valid), 1);
      chk($sformatf("bp_wrap%0d", k), int'(wrap), ewrap);
      out_if.out_ready = rdy_pat[k % 16];
      tick();
      if (rdy_pat[k % 16]) begin
        if (eidx == 5) begin
          eidx = 0; ewrap = 1;
        end else begin
          eidx++; ewrap = 0;
        end
      end else begin
        ewrap = 0;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("bp_stop_valid", int'(out_if.out_valid), 0);
    out_if.out_ready = 1'b1;

    // Custom pattern 3,1,2 one-shot.
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1'b1; cfg_addr = ADDR_W'(i); cfg_wdata = DATA_W'(custom[i]);
      tick();
    end
    cfg_we = 1'b0;
    cfg_len_we = 1'b1; cfg_len = LEN_W'(3);
    tick();
    cfg_len_we = 1'b0;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("os_data%0d", k), int'(out_if.out_data), custom[k]);
      chk($sformatf("os_valid%0d", k), int'(out_if.out_valid), 1);
      chk($sformatf("os_done%0d", k), int'(done), 0);
      tick();
    end
    chk("os_end_valid", int'(out_if.out_valid), 0);
    chk("os_end_busy",  int'(busy), 0);
    chk("os_end_done",  int'(done), 1);
    chk("os_end_wrap",  int'(wrap), 0);
    tick();
    chk("os_done_clear", int'(done), 0);
    chk("os_idle_valid", int'(out_if.out_valid), 0);

    // len = 1, one-shot with start held high.
    cfg_len_we = 1'b1; cfg_len = LEN_W'(1);
    tick();
    cfg_len_we = 1'b0;
    mode = 1'b1; start = 1'b1;
    tick();
    chk("l1_os_valid", int'(out_if.out_valid), 1);
    chk("l1_os_data",  int'(out_if.out_data), 3);
    tick();
    chk("l1_os_done",  int'(done), 1);
    chk("l1_os_idle",  int'(out_if.out_valid), 0);
    tick();
    chk("l1_restart_valid", int'(out_if.out_valid), 1);
    chk("l1_restart_done",  int'(done), 0);
    chk("l1_restart_data",  int'(out_if.out_data), 3);
    start = 1'b0;
    tick();
    chk("l1_os_done2", int'(done), 1);
    tick();

    // len = 1, repeat: wrap on every beat.
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("l1_rep_wrap0",  int'(wrap), 0);
    chk("l1_rep_valid0", int'(out_if.out_valid), 1);
    tick();
    chk("l1_rep_wrap1", int'(wrap), 1);
    chk("l1_rep_data1", int'(out_if.out_data), 3);
    tick();
    chk("l1_rep_wrap2", int'(wrap), 1);

    // Reset mid-run restores legacy pattern and len.
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", int'(out_if.out_valid), 0);
    chk("mrst_data",  int'(out_if.out_data), 0);
    chk("mrst_busy",  int'(busy), 0);
    chk("mrst_wrap",  int'(wrap), 0);
    tick();
    rst_n = 1'b1;
    tick();
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("post_rst_data%0d", k), int'(out_if.out_data), legacy[k % 6]);
      chk($sformatf("post_rst_wrap%0d", k), int'(wrap), (k == 6) ? 1 : 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
